// File: rtl/sample_delay_writer_pkg.sv
// rtl/sample_delay_writer_pkg.sv - shared types for the sample delay writer
package sample_delay_writer_pkg;

    // Capture state: IDLE holds RAM and count, FILL is priming, RUN is steady state
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Any non-idle state accepts samples
    function automatic logic is_active(input state_t st);
        return (st != ST_IDLE);
    endfunction

endpackage

// File: rtl/sample_delay_writer_if.sv
// rtl/sample_delay_writer_if.sv - sample in/out stream bundle for the delay writer
interface sample_delay_writer_if #(
    parameter int DATA_WIDTH = 8
) ();

    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;

    // Upstream/downstream side: drives samples, observes the delayed stream
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    // Delay writer side
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/sample_delay_writer_ram2port.sv
// rtl/sample_delay_writer_ram2port.sv - simple dual-port RAM, registered read, old-data on collision
module ram2port #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     rd_en,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] rd_q;

    // Storage array is never reset; stale contents are masked by the caller
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register samples the array before this edge's write lands, so a
    // same-address read returns the previous contents; it holds when not read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else if (rd_en) begin
            rd_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_q;

endmodule

// File: rtl/sample_delay_writer.sv
// rtl/sample_delay_writer.sv - capture FSM writing a ring buffer and replaying samples delayed by offset
module sample_delay_writer
    import sample_delay_writer_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic [ADDRESS_WIDTH-1:0] offset,
    sample_delay_writer_if.slave     s,
    output logic                     full,
    output logic                     busy
);

    // Count is one bit wider than the pointer so it can represent DEPTH itself
    localparam logic [ADDRESS_WIDTH:0] DEPTH_C = {1'b1, {ADDRESS_WIDTH{1'b0}}};

    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] wr_ptr;
    logic [ADDRESS_WIDTH:0]   count;
    logic                     out_valid_q;

    logic                     active;
    logic                     transfer;
    logic                     wr_en;
    logic [ADDRESS_WIDTH-1:0] rd_addr;
    logic [ADDRESS_WIDTH:0]   eff_offset;
    logic [ADDRESS_WIDTH:0]   count_inc;

    // Handshake and status decode straight from the state register
    assign active     = is_active(state);
    assign s.in_ready = active;
    assign busy       = active;
    assign transfer   = s.in_valid && active;

    // stop and start both pre-empt the sample on their cycle; nothing is written
    assign wr_en      = transfer && !stop && !start;

    // Pointer subtraction wraps naturally; offset 0 reads the slot about to be
    // overwritten, which is the sample from DEPTH transfers ago
    assign rd_addr    = wr_ptr - offset;
    assign eff_offset = (offset == '0) ? DEPTH_C : {1'b0, offset};
    assign count_inc  = (count == DEPTH_C) ? count : count + 1'b1;

    assign full        = (count == DEPTH_C);
    assign s.out_valid = out_valid_q;

    ram2port #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (s.in_data),
        .rd_en   (wr_en),
        .rd_addr (rd_addr),
        .rd_data (s.out_data)
    );

    // Capture FSM with pointer, saturating count and the delayed-valid pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            wr_ptr      <= '0;
            count       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_FILL;
                        wr_ptr <= '0;
                        count  <= '0;
                    end
                end
                ST_FILL, ST_RUN: begin
                    if (stop) begin
                        state <= ST_IDLE;
                    end else if (start) begin
                        state  <= ST_FILL;
                        wr_ptr <= '0;
                        count  <= '0;
                    end else if (transfer) begin
                        wr_ptr      <= wr_ptr + 1'b1;
                        count       <= count_inc;
                        // Only replay once the requested delay is backed by
                        // samples from this capture, hiding stale RAM
                        out_valid_q <= (count >= eff_offset);
                        if ((state == ST_FILL) && (count_inc == DEPTH_C)) begin
                            state <= ST_RUN;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_delay_writer.sv
// tb/tb_sample_delay_writer.sv - randomized scoreboard bench for sample_delay_writer
module tb_sample_delay_writer;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [AW-1:0] offset = '0;
    logic          full;
    logic          busy;

    sample_delay_writer_if #(.DATA_WIDTH(DW)) bus ();

    sample_delay_writer #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .stop   (stop),
        .offset (offset),
        .s      (bus),
        .full   (full),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          e;
        logic [DW-1:0] d;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] hist[$];
    bit            active = 1'b0;
    int            edge_no = 0;
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, req, edge_no);
        end
    endtask

    // Reference model: a capture is the list of samples accepted since start;
    // a transfer replays the sample eff_offset positions back in that list
    task automatic model_edge(input logic v, input logic [DW-1:0] d, input logic st, input logic sp);
        int n;
        int eff;
        if (!active) begin
            if (st) begin
                active = 1'b1;
                hist.delete();
            end
        end else if (sp) begin
            active = 1'b0;
        end else if (st) begin
            hist.delete();
        end else if (v) begin
            n   = hist.size();
            eff = (offset == 0) ? DEPTH : int'(offset);
            if (n >= eff) exp_q.push_back('{edge_no, hist[n-eff]});
            hist.push_back(d);
        end
    endtask

    task automatic step(input logic v, input logic [DW-1:0] d, input logic st, input logic sp);
        bus.in_valid = v;
        bus.in_data  = d;
        start        = st;
        stop         = sp;
        @(posedge clk);
        edge_no++;
        model_edge(v, d, st, sp);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"}, int'(bus.out_valid), 0);
        check({tag, "_out_data"}, int'(bus.out_data), 0);
        check({tag, "_full"}, int'(full), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_in_ready"}, int'(bus.in_ready), 0);
    endtask

    // Monitor: status every cycle, delayed samples popped from the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", int'(bus.in_ready), int'(active));
            check("busy", int'(busy), int'(active));
            check("full", int'(full), int'(hist.size() >= DEPTH));
            if (exp_q.size() > 0 && exp_q[0].e == edge_no) begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_valid", int'(bus.out_valid), 1);
                check("out_data", int'(bus.out_data), int'(e.d));
            end else begin
                check("out_valid", int'(bus.out_valid), 0);
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        #1 rst_n = 1'b1;
        #1;

        // Offset 3, counting data
        offset = 4'd3;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 24; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Offset 0 means a full-depth delay
        offset = 4'd0;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 8'hAA, 1'b0, 1'b0);

        // Offset 5 across two pointer wraps, random data
        offset = 4'd5;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);

        // Gapped valid with a random offset (restart from RUN)
        offset = AW'($urandom_range(1, 15));
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) step(i[0] == 1'b0, DW'($urandom), 1'b0, 1'b0);

        // stop and start together in RUN with data offered
        offset = 4'd2;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);

        // Asynchronous reset between edges mid-FILL
        offset = 4'd3;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, DW'(8'h50 + i), 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        active = 1'b0;
        hist.delete();
        exp_q.delete();
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        edge_no++;
        #3 rst_n = 1'b1;
        #3;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 24; i++) step(1'b1, DW'(i), 1'b0, 1'b0);

        // Random control, data and offset changes on the fly
        for (int i = 0; i < 400; i++) begin
            int  r;
            logic v, st, sp;
            r  = int'($urandom_range(0, 99));
            st = (r < 3);
            sp = (r >= 3 && r < 6);
            if ($urandom_range(0, 19) == 0) offset = AW'($urandom);
            v = ($urandom_range(0, 3) != 0);
            if (st) v = 1'b0;
            step(v, DW'($urandom), st, sp);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
